// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
//   Post-PLL bring-up sequencer. Synchronizes the PLL lock flag, releases an
//   active-low system reset once lock has been stable for HOLD_CYCLES, and
//   re-asserts it after DROP_FILTER consecutive unlocked cycles. While running,
//   it emits a one-cycle clock-enable strobe every TICK_DIV cycles and keeps a
//   saturating count of lock-loss events.
//
// Ports
//   clock           in   PLL output clock, sole clock
//   reset_n         in   asynchronous active-low reset, clears every flop
//   locked          in   PLL lock flag, asynchronous to clock
//   sys_reset_n     out  system reset, active-low, high only in RUN
//   tick            out  one-cycle strobe every TICK_DIV cycles in RUN
//   lock_lost_count out  saturating count of RUN -> WAIT_LOCK transitions
//   seq_state       out  WAIT_LOCK=0, STABILIZE=1, RUN=2

module pll_reset_sequencer #(
  parameter int unsigned HOLD_CYCLES = 1024,
  parameter int unsigned DROP_FILTER = 4,
  parameter int unsigned TICK_DIV    = 159
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       locked,
  output logic       sys_reset_n,
  output logic       tick,
  output logic [7:0] lock_lost_count,
  output logic [1:0] seq_state
);

  // Counter widths; a parameter of 1 still needs a 1-bit counter.
  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned DROP_W = (DROP_FILTER > 1) ? $clog2(DROP_FILTER) : 1;
  localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [DROP_W-1:0] DROP_LAST = DROP_W'(DROP_FILTER - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILIZE = 2'd1,
    RUN       = 2'd2
  } seq_state_e;

  seq_state_e        state_q, state_d;
  logic [1:0]        sync_q;
  logic              lock_s;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [7:0]        lost_q, lost_d;
  logic              tick_q, tick_d;
  logic              sys_reset_n_q, sys_reset_n_d;

  // Two-flop synchronizer; lock_s is the only consumer-visible lock flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], locked};
    end
  end

  assign lock_s = sync_q[1];

  // Next-state, counter and output computation.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    drop_cnt_d = drop_cnt_q;
    tick_cnt_d = tick_cnt_q;
    lost_d     = lost_q;
    tick_d     = 1'b0;

    case (state_q)
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d    = STABILIZE;
          hold_cnt_d = '0;
        end
      end

      STABILIZE: begin
        if (!lock_s) begin
          // Any glitch restarts the hold from scratch.
          state_d    = WAIT_LOCK;
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d    = RUN;
          hold_cnt_d = '0;
          drop_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end

      RUN: begin
        if (lock_s) begin
          drop_cnt_d = '0;
        end else if (drop_cnt_q == DROP_LAST) begin
          state_d    = WAIT_LOCK;
          drop_cnt_d = '0;
          lost_d     = (lost_q == 8'hFF) ? lost_q : lost_q + 8'd1;
        end else begin
          drop_cnt_d = drop_cnt_q + DROP_W'(1);
        end
      end

      default: begin
        state_d    = WAIT_LOCK;
        hold_cnt_d = '0;
        drop_cnt_d = '0;
      end
    endcase

    // Ticks only while remaining in RUN, so the exit edge never strobes.
    if ((state_q == RUN) && (state_d == RUN)) begin
      if (tick_cnt_q == TICK_LAST) begin
        tick_cnt_d = '0;
        tick_d     = 1'b1;
      end else begin
        tick_cnt_d = tick_cnt_q + TICK_W'(1);
      end
    end else begin
      tick_cnt_d = '0;
    end

    // Reset output tracks the state register edge-for-edge.
    sys_reset_n_d = (state_d == RUN);
  end

  // State and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= WAIT_LOCK;
      hold_cnt_q    <= '0;
      drop_cnt_q    <= '0;
      tick_cnt_q    <= '0;
      lost_q        <= 8'd0;
      tick_q        <= 1'b0;
      sys_reset_n_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      drop_cnt_q    <= drop_cnt_d;
      tick_cnt_q    <= tick_cnt_d;
      lost_q        <= lost_d;
      tick_q        <= tick_d;
      sys_reset_n_q <= sys_reset_n_d;
    end
  end

  assign sys_reset_n     = sys_reset_n_q;
  assign tick            = tick_q;
  assign lock_lost_count = lost_q;
  assign seq_state       = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer
//   Scoreboard bench: each scenario pushes the expected output vector
//   {seq_state, sys_reset_n, tick, lock_lost_count} for specific clock edges,
//   derived from the documented edge timing; a negedge monitor pops and compares.

module tb_pll_reset_sequencer;

  localparam int unsigned HOLD = 8;
  localparam int unsigned DROP = 4;
  localparam int unsigned TDIV = 5;

  localparam logic [1:0] S_WAIT = 2'd0;
  localparam logic [1:0] S_STAB = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  logic       clock;
  logic       reset_n;
  logic       locked;
  logic       sys_reset_n;
  logic       tick;
  logic [7:0] lock_lost_count;
  logic [1:0] seq_state;

  pll_reset_sequencer #(
    .HOLD_CYCLES(HOLD),
    .DROP_FILTER(DROP),
    .TICK_DIV   (TDIV)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .locked         (locked),
    .sys_reset_n    (sys_reset_n),
    .tick           (tick),
    .lock_lost_count(lock_lost_count),
    .seq_state      (seq_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Count of rising edges seen so far.
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int          c;
    int          scen;
    logic [11:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  logic [11:0] obs;
  assign obs = {seq_state, sys_reset_n, tick, lock_lost_count};

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h (state/rst/tick/lost)", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] mk(logic [1:0] st, logic rst, logic tk, logic [7:0] lost);
    return {st, rst, tk, lost};
  endfunction

  function automatic void push(int c, int scen, logic [1:0] st, logic rst, logic tk,
                               logic [7:0] lost);
    exp_t e;
    e.c    = c;
    e.scen = scen;
    e.v    = mk(st, rst, tk, lost);
    sb.push_back(e);
  endfunction

  // RUN cycle with the tick due every TDIV edges after entry edge e.
  function automatic void push_run(int c, int scen, int e, logic [7:0] lost);
    logic tk;
    tk = (c > e) && (((c - e) % TDIV) == 0);
    push(c, scen, S_RUN, 1'b1, tk, lost);
  endfunction

  // Monitor: compare every expectation due at this edge.
  always @(negedge clock) begin
    while (sb.size() != 0 && sb[0].c <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.c < cyc)
        check($sformatf("s%0d_stale_c%0d", e.scen, e.c), 12'd0, 12'd1);
      else
        check($sformatf("s%0d_c%0d", e.scen, e.c), obs, e.v);
    end
  end

  task automatic go_to(input int c);
    while (cyc < c) @(negedge clock);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    int e_run;
    logic [7:0] lost;

    reset_n = 1'b0;
    locked  = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_state", obs, mk(S_WAIT, 1'b0, 1'b0, 8'd0));

    // 1: release after lock
    b = cyc;
    reset_n = 1'b1;
    locked  = 1'b1;
    push(b + 1, 1, S_WAIT, 1'b0, 1'b0, 8'd0);
    push(b + 2, 1, S_WAIT, 1'b0, 1'b0, 8'd0);
    for (int k = 3; k <= 10; k++) push(b + k, 1, S_STAB, 1'b0, 1'b0, 8'd0);
    push(b + 11, 1, S_RUN, 1'b1, 1'b0, 8'd0);
    e_run = b + 11;

    // 2: tick cadence over 30 cycles
    for (int k = 12; k <= 41; k++) push_run(b + k, 2, e_run, 8'd0);
    go_to(b + 41);

    // 3a: 3-cycle drop is filtered
    b = cyc;
    locked = 1'b0;
    for (int k = 1; k <= 10; k++) push_run(b + k, 3, e_run, 8'd0);
    go_to(b + 3);
    locked = 1'b1;
    go_to(b + 10);

    // 3b: 4-cycle drop forces reset on an edge where a tick was due
    while (((cyc + 6 - e_run) % TDIV) != 0) @(negedge clock);
    b = cyc;
    locked = 1'b0;
    for (int k = 1; k <= 5; k++) push_run(b + k, 3, e_run, 8'd0);
    push(b + 6, 3, S_WAIT, 1'b0, 1'b0, 8'd1);
    for (int k = 7; k <= 14; k++) push(b + k, 3, S_STAB, 1'b0, 1'b0, 8'd1);
    push(b + 15, 3, S_RUN, 1'b1, 1'b0, 8'd1);
    go_to(b + 4);
    locked = 1'b1;
    go_to(b + 15);
    e_run = b + 15;

    // 4: drop, then a one-cycle glitch during STABILIZE restarts the hold
    b = cyc;
    locked = 1'b0;
    for (int k = 1; k <= 5; k++) push_run(b + k, 4, e_run, 8'd1);
    for (int k = 6; k <= 10; k++) push(b + k, 4, S_WAIT, 1'b0, 1'b0, 8'd2);
    go_to(b + 10);
    b = cyc;
    locked = 1'b1;
    push(b + 1, 4, S_WAIT, 1'b0, 1'b0, 8'd2);
    push(b + 2, 4, S_WAIT, 1'b0, 1'b0, 8'd2);
    for (int k = 3; k <= 6; k++) push(b + k, 4, S_STAB, 1'b0, 1'b0, 8'd2);
    push(b + 7, 4, S_WAIT, 1'b0, 1'b0, 8'd2);
    for (int k = 8; k <= 15; k++) push(b + k, 4, S_STAB, 1'b0, 1'b0, 8'd2);
    push(b + 16, 4, S_RUN, 1'b1, 1'b0, 8'd2);
    go_to(b + 4);
    locked = 1'b0;
    go_to(b + 5);
    locked = 1'b1;
    go_to(b + 16);
    e_run = b + 16;

    // 5: 260 lock/drop cycles saturate the loss counter
    lost = 8'd2;
    for (int i = 0; i < 260; i++) begin
      b = cyc;
      lost = (lost == 8'd255) ? lost : lost + 8'd1;
      locked = 1'b0;
      push(b + 6, 5, S_WAIT, 1'b0, 1'b0, lost);
      push(b + 17, 5, S_RUN, 1'b1, 1'b0, lost);
      go_to(b + 6);
      locked = 1'b1;
      go_to(b + 17);
    end
    check("sat_count", {4'd0, lock_lost_count}, 12'd255);
    e_run = cyc;

    // 6: asynchronous reset while the tick is high
    for (int k = 1; k <= 5; k++) push_run(e_run + k, 6, e_run, 8'd255);
    go_to(e_run + 5);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset", obs, mk(S_WAIT, 1'b0, 1'b0, 8'd0));
    repeat (2) @(negedge clock);
    check("reset_held", obs, mk(S_WAIT, 1'b0, 1'b0, 8'd0));
    b = cyc;
    reset_n = 1'b1;
    push(b + 1, 6, S_WAIT, 1'b0, 1'b0, 8'd0);
    push(b + 2, 6, S_WAIT, 1'b0, 1'b0, 8'd0);
    for (int k = 3; k <= 10; k++) push(b + k, 6, S_STAB, 1'b0, 1'b0, 8'd0);
    push(b + 11, 6, S_RUN, 1'b1, 1'b0, 8'd0);
    go_to(b + 11);

    repeat (3) @(negedge clock);
    check("sb_drain", 12'(sb.size()), 12'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Sequences system bring-up downstream of the PLL. It runs on the PLL output clock and takes the PLL's asynchronous `locked` flag. It releases a synchronized, delayed active-low system reset only after lock has been stable for a programmable hold time, and it re-asserts that reset when lock is lost for a filtered number of cycles. While running, it generates a periodic single-cycle clock-enable strobe for slow logic, and it counts lock-loss events for debug.

## Interface
Parameters:
- `HOLD_CYCLES`, default 1024: number of consecutive synchronized-lock cycles required before reset release; must be ≥1.
- `DROP_FILTER`, default 4: number of consecutive synchronized-unlock cycles in RUN that force reset; must be ≥1.
- `TICK_DIV`, default 159: `tick` period in clock cycles (1 MHz at 159 MHz); must be ≥2.

Ports:
- `clock`, input, 1: PLL output clock; sole clock.
- `reset_n`, input, 1: reset, asynchronous, active-low; clears every flop, including the synchronizer.
- `locked`, input, 1: PLL lock flag; asynchronous to `clock`.
- `sys_reset_n`, output, 1: system reset, active-low, registered; high only in RUN.
- `tick`, output, 1: one-cycle strobe every `TICK_DIV` cycles in RUN; 0 otherwise.
- `lock_lost_count`, output, 8: saturating count of RUN→WAIT_LOCK transitions.
- `seq_state`, output, 2: current state (WAIT_LOCK=0, STABILIZE=1, RUN=2); 3 is unused.

## Operation
- **Lock synchronizer.** `locked` passes through a 2-flop synchronizer, producing `lock_s`. No other logic samples `locked` directly.
- **WAIT_LOCK.** If `lock_s`=1, go to STABILIZE and set `hold_cnt`=0.
- **STABILIZE.**
  - If `lock_s`=0, return to WAIT_LOCK. The hold restarts from scratch on re-lock.
  - Otherwise, if `hold_cnt`==`HOLD_CYCLES`-1, go to RUN, set `tick_cnt`=0 and `drop_cnt`=0.
  - Otherwise increment `hold_cnt`.
- **RUN.**
  - If `lock_s`=1, set `drop_cnt`=0.
  - If `lock_s`=0 and `drop_cnt`==`DROP_FILTER`-1, go to WAIT_LOCK and increment `lock_lost_count`, saturating at 255.
  - If `lock_s`=0 otherwise, increment `drop_cnt`.
- **Reset output.** `sys_reset_n` is registered and set/cleared on the same edge as entry to or exit from RUN, so `sys_reset_n`==(`seq_state`==RUN) at all times.
- **Tick generator.** Each edge in RUN:
  - If `tick_cnt`==`TICK_DIV`-1, set `tick_cnt`=0 and `tick`=1.
  - Otherwise increment `tick_cnt` and set `tick`=0.
  - Outside RUN, `tick`=0 and `tick_cnt` holds at 0.
  - On the edge that leaves RUN, `tick` is forced to 0, even if a tick was due.
- **Counter widths.** Counters are sized with `$clog2` of their parameter. No counter passes its terminal value.
- **Reset mid-operation.** Asserting `reset_n` in any state immediately (asynchronously) forces:
  - state = WAIT_LOCK;
  - `sys_reset_n`=0, `tick`=0, `lock_lost_count`=0;
  - all counters and synchronizer flops = 0.
- **After reset deassertion.** Normal sequencing resumes from WAIT_LOCK. With `locked` already high, the full synchronizer and hold latency applies again.

## Timing
Numbering: edge 1 is the first rising edge that samples `locked`=1 (or 0, for drops).
- **Synchronizer.** `lock_s` changes after edge 2.
- **Lock to release.**
  - STABILIZE is entered at edge 3.
  - `sys_reset_n` rises at edge `HOLD_CYCLES`+3 when `locked` stays high throughout.
- **Lock drop to reset.**
  - `sys_reset_n` falls at edge `DROP_FILTER`+2.
  - A `locked` low pulse shorter than `DROP_FILTER` cycles in RUN has no effect, other than clearing `drop_cnt` afterwards.
- **Tick.**
  - The first `tick` goes high after the `TICK_DIV`th edge following RUN entry.
  - Subsequent ticks occur every `TICK_DIV` edges, each exactly 1 cycle wide.
- **Count update.** `lock_lost_count` updates on the same edge that `sys_reset_n` falls.
- **Asynchronous reset.** Outputs reach their reset values without a clock edge.

## Test plan
Bench parameters: `HOLD_CYCLES`=8, `DROP_FILTER`=4, `TICK_DIV`=5.
1. **Release after lock.** Apply reset, release `reset_n`, raise `locked` before edge 1. `seq_state` reads 1 after edge 3, and `sys_reset_n` rises at edge 11.
2. **Tick cadence.** After scenario 1, run 30 cycles. `tick` goes high after edge 16, then after edges 21, 26, and 31, each 1 cycle wide and never 2 in a row.
3. **Drop filtering.**
   - In RUN, pull `locked` low for 3 cycles: `sys_reset_n` stays 1 and `lock_lost_count` stays 0.
   - Pull it low for 4 cycles: `sys_reset_n` falls at edge 6 relative to the first low sample, `lock_lost_count`=1, and `tick`=0.
4. **Unstable lock during hold.** Toggle `locked` low for 1 cycle during STABILIZE: the state returns to WAIT_LOCK, and `sys_reset_n` rises only 11 edges after the re-lock sample.
5. **Counter saturation.** Perform 260 lock/drop cycles: `lock_lost_count` stops at 255.
6. **Reset mid-RUN.**
   - Assert `reset_n` low mid-RUN, mid-tick period: `sys_reset_n`, `tick`, and `lock_lost_count` go to 0 immediately, and `seq_state`=0.
   - Release `reset_n` with `locked` held high: release recurs at edge 11.
